imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage. It decodes all RV32I immediate formats (I, S, B, U, J), sign-extends them to XLEN, and precomputes PC-relative targets for branches, JAL and AUIPC. Results pass through a valid/ready output FIFO, so decode can absorb stalls from the execute stage. It also reports a format code, an illegal-opcode flag and a saturating illegal-instruction counter.

---
 rtl/imm_pkg.sv | 72 +++++++
 rtl/imm_fifo.sv | 53 +++++
 rtl/imm_gen_pipe.sv | 81 ++++++++
 tb/tb_imm_gen_pipe.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared decode definitions for the immediate generator:
// opcode constants, format encoding and the raw immediate decode.
package imm_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [31:0] imm;
        fmt_e        fmt;
        logic        illegal;
    } dec_t;

    // imm is already sign-extended to 32 bits; wider XLEN is
    // handled by the caller.
    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        d.imm     = '0;
        d.fmt     = FMT_NONE;
        d.illegal = 1'b0;
        unique case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: begin
                d.fmt = FMT_I;
                d.imm = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                d.fmt = FMT_S;
                d.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                d.fmt = FMT_B;
                d.imm = {{19{instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                d.fmt = FMT_U;
                d.imm = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                d.fmt = FMT_J;
                d.imm = {{11{instr[31]}}, instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};
            end
            OP_REG: begin
                d.fmt = FMT_NONE;
            end
            default: begin
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_fifo.sv
// Generic synchronous FIFO; caller qualifies push/pop with its own
// handshake. Ports: push/in_data, pop/out_data (head), count, flush.
module imm_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign out_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator with PC-relative target, output
// FIFO and saturating illegal counter. Ports: in_* / out_* handshakes,
// flush, cnt_clr, illegal_cnt.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_target,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int EW = 2 * XLEN + 4;
    localparam int CW = $clog2(DEPTH + 1);

    dec_t            dec;
    logic [XLEN-1:0] imm_x;
    logic [XLEN-1:0] target;
    logic            has_tgt;
    logic            push;
    logic            pop;
    logic [CW-1:0]   fill;
    logic [EW-1:0]   head;

    assign dec   = decode(in_instr);
    assign imm_x = XLEN'($signed(dec.imm));

    // JALR is I-format but has no precomputed target.
    assign has_tgt = (dec.fmt == FMT_B) || (dec.fmt == FMT_J) ||
                     (in_instr[6:0] == OP_AUIPC);
    assign target  = has_tgt ? in_pc + imm_x : '0;

    // Ready comes from registered occupancy only.
    assign in_ready  = (fill != CW'(DEPTH));
    assign out_valid = (fill != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    imm_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (push),
        .in_data  ({imm_x, target, dec.fmt, dec.illegal}),
        .pop      (pop),
        .out_data (head),
        .count    (fill)
    );

    assign {out_imm, out_target, out_fmt, out_illegal} = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (cnt_clr) begin
            illegal_cnt <= '0;
        end else if (push && dec.illegal &&
                     (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: table vectors through a
// scoreboard, plus backpressure, flush, reset and 64-bit cases.
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] tgt;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_imm, out_target;
    logic [2:0]  out_fmt;
    logic        out_illegal, flush, cnt_clr;
    logic [15:0] illegal_cnt;

    logic        v_in_valid, v_in_ready, v_out_valid, v_out_ready;
    logic [31:0] v_instr;
    logic [63:0] v_pc, v_imm, v_target;
    logic [2:0]  v_fmt;
    logic        v_illegal, v_flush, v_cnt_clr;
    logic [1:0]  v_cnt;

    int   total = 0;
    int   bad   = 0;
    int   pops  = 0;
    int   stalls;
    int   p0;
    vec_t q[$];
    vec_t cur;
    vec_t tab[12];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_target(out_target),
        .out_fmt(out_fmt), .out_illegal(out_illegal),
        .flush(flush), .cnt_clr(cnt_clr),
        .illegal_cnt(illegal_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2), .CNT_W(2)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v_in_valid), .in_ready(v_in_ready),
        .in_instr(v_instr), .in_pc(v_pc),
        .out_valid(v_out_valid), .out_ready(v_out_ready),
        .out_imm(v_imm), .out_target(v_target),
        .out_fmt(v_fmt), .out_illegal(v_illegal),
        .flush(v_flush), .cnt_clr(v_cnt_clr),
        .illegal_cnt(v_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Evaluate handshakes at the negedge, then advance one edge.
    task automatic step();
        vec_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            pops++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected imm=%h", out_imm);
            end else begin
                e = q.pop_front();
                if ({out_imm, out_target, out_fmt, out_illegal} !==
                    {e.imm, e.tgt, e.fmt, e.ill}) begin
                    bad++;
                    $display("FAIL pop instr=%h actual=%h/%h/%0d/%b required=%h/%h/%0d/%b",
                             e.instr, out_imm, out_target, out_fmt,
                             out_illegal, e.imm, e.tgt, e.fmt, e.ill);
                end
            end
        end
        if (flush) q.delete();
        else if (in_valid && in_ready) q.push_back(cur);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_instr = v.instr;
        in_pc    = v.pc;
        cur      = v;
    endtask

    task automatic send(input vec_t v);
        logic acc;
        int   n = 0;
        drive(v);
        do begin
            acc = in_ready;
            if (!acc) stalls++;
            step();
            n++;
        end while (!acc && n < 20);
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   n;
        tab[0]  = '{32'hFFF00093, 32'h100,      32'hFFFFFFFF, 32'h0,    3'd1, 1'b0};
        tab[1]  = '{32'hFE000CE3, 32'h1000,     32'hFFFFFFF8, 32'hFF8,  3'd3, 1'b0};
        tab[2]  = '{32'h0010006F, 32'h200,      32'h800,      32'hA00,  3'd5, 1'b0};
        tab[3]  = '{32'h00112423, 32'h300,      32'h8,        32'h0,    3'd2, 1'b0};
        tab[4]  = '{32'h12345037, 32'h400,      32'h12345000, 32'h0,    3'd4, 1'b0};
        tab[5]  = '{32'hFFFFF017, 32'h2000,     32'hFFFFF000, 32'h1000, 3'd4, 1'b0};
        tab[6]  = '{32'h00408067, 32'h500,      32'h4,        32'h0,    3'd1, 1'b0};
        tab[7]  = '{32'h002081B3, 32'h600,      32'h0,        32'h0,    3'd0, 1'b0};
        tab[8]  = '{32'h0000007F, 32'h700,      32'h0,        32'h0,    3'd0, 1'b1};
        tab[9]  = '{32'h00000463, 32'hFFFFFFFC, 32'h8,        32'h4,    3'd3, 1'b0};
        tab[10] = '{32'hFFFFFFFF, 32'h800,      32'h0,        32'h0,    3'd0, 1'b1};
        tab[11] = '{32'h80002003, 32'h900,      32'hFFFFF800, 32'h0,    3'd1, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        v_in_valid = 1'b0; v_instr = '0; v_pc = '0;
        v_out_ready = 1'b1; v_flush = 1'b0; v_cnt_clr = 1'b0;
        cur = '0;

        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_target", 64'(out_target), 64'd0);
        chk("rst_fmt", 64'(out_fmt), 64'd0);
        chk("rst_illegal", 64'(out_illegal), 64'd0);
        chk("rst_cnt", 64'(illegal_cnt), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single-cycle latency into an empty FIFO
        drive(tab[0]);
        step();
        in_valid = 1'b0;
        chk("lat_out_valid", 64'(out_valid), 64'd1);
        chk("lat_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        chk("lat_empty", 64'(out_valid), 64'd0);

        // full-rate stream of the table
        stalls = 0;
        for (int i = 0; i < 12; i++) send(tab[i]);
        chk("stream_stalls", 64'(stalls), 64'd0);
        drain();
        chk("stream_cnt", 64'(illegal_cnt), 64'd2);

        // backpressure: 2 accepted, third held
        out_ready = 1'b0;
        p0 = pops;
        send(tab[1]);
        send(tab[2]);
        chk("bp_full", 64'(in_ready), 64'd0);
        drive(tab[3]);
        step();
        chk("bp_held", 64'(in_ready), 64'd0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        n = 0;
        do begin
            acc = in_ready;
            step();
            n++;
        end while (!acc && n < 10);
        in_valid = 1'b0;
        chk("bp_accept", 64'(acc), 64'd1);
        drain();
        chk("bp_pops", 64'(pops - p0), 64'd3);

        // clear wins over an increment in the same cycle
        drive(tab[8]);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_cnt", 64'(illegal_cnt), 64'd0);
        drain();
        drive(tab[8]);
        step();
        in_valid = 1'b0;
        chk("ill_cnt1", 64'(illegal_cnt), 64'd1);
        drain();

        // flush with FIFO full and in_valid high
        out_ready = 1'b0;
        send(tab[0]);
        send(tab[1]);
        flush = 1'b1;
        drive(tab[8]);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        chk("flush_cnt", 64'(illegal_cnt), 64'd1);

        // flush drops an input that would otherwise be accepted
        send(tab[2]);
        flush = 1'b1;
        drive(tab[10]);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("drop_cnt", 64'(illegal_cnt), 64'd1);
        out_ready = 1'b1;
        p0 = pops;
        repeat (3) step();
        chk("drop_valid", 64'(out_valid), 64'd0);
        chk("drop_pops", 64'(pops - p0), 64'd0);

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        send(tab[4]);
        send(tab[5]);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_imm", 64'(out_imm), 64'd0);
        chk("arst_target", 64'(out_target), 64'd0);
        chk("arst_fmt", 64'(out_fmt), 64'd0);
        chk("arst_illegal", 64'(out_illegal), 64'd0);
        chk("arst_cnt", 64'(illegal_cnt), 64'd0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // XLEN=64: LUI sign extension, JAL target wrap
        v_in_valid = 1'b1;
        v_instr = 32'h800000B7;
        v_pc = 64'h10;
        step();
        v_in_valid = 1'b0;
        chk("x64_lui_valid", 64'(v_out_valid), 64'd1);
        chk("x64_lui_imm", v_imm, 64'hFFFFFFFF80000000);
        chk("x64_lui_fmt", 64'(v_fmt), 64'd4);
        chk("x64_lui_tgt", v_target, 64'd0);
        v_in_valid = 1'b1;
        v_instr = 32'h0010006F;
        v_pc = 64'hFFFFFFFFFFFFFF00;
        step();
        v_in_valid = 1'b0;
        chk("x64_jal_imm", v_imm, 64'h800);
        chk("x64_jal_tgt", v_target, 64'h700);

        // CNT_W=2 saturation
        v_in_valid = 1'b1;
        v_instr = 32'h0000007F;
        repeat (5) step();
        v_in_valid = 1'b0;
        chk("x64_cnt_sat", 64'(v_cnt), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
